nba_delay_line: RTL

- Parametrised, clocked successor to the fixed "reg <= #10 a && b" assignment pattern.
- Each accepted input sample is reduced by a selectable boolean operator. The result is delivered on the output exactly D clock cycles later, where D is a programmable latency latched at the start of each burst.
- Sits in the regression library as a reusable delayed-assignment generator for scheduling and event-ordering tests.

---
 rtl/nba_delay_line.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nba_delay_line.sv
// nba_delay_line
//   Clocked, parametrised replacement for the "reg <= #10 a && b" pattern.
//   Each accepted sample is reduced by the selected operator and delivered on
//   the output exactly D rising edges after the accept edge. D is the clamped
//   delay request, latched into cur_delay at the start of each burst.
//
// Parameters
//   WIDTH     operand/result width (>=1)
//   MAX_DELAY maximum latency and number of internal stages (>=2)
//   DW        width of the delay / cur_delay ports (must hold MAX_DELAY)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous clear of all in-flight samples
//   in_valid/in_ready   input handshake
//   in_a, in_b, op      operands and operator (00 A, 01 A&&B, 10 A&B, 11 A^B)
//   delay               requested latency (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   out_valid/out_data  delayed result; out_data holds between pulses
//   busy                at least one sample in flight
//   cur_delay           latency currently in force
//
// Optional feature
//   NBA_DELAY_LINE_XINIT_EN: out_data resets to all-X instead of 0.

module nba_delay_line #(
  parameter int WIDTH     = 4,
  parameter int MAX_DELAY = 16,
  parameter int DW        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  input  logic [DW-1:0]    delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [DW-1:0]    cur_delay
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [DW-1:0]                 eff;
  logic [DW-1:0]                 cnt, cnt_nxt;
  logic [WIDTH-1:0]              res;
  logic                          accept;

  // Stage k holds a sample that reaches the output k edges from now.
  logic [MAX_DELAY:1]            sv, sv_n;
  logic [MAX_DELAY:1][WIDTH-1:0] sd, sd_n;

  always_comb begin
    if (delay == '0)
      eff = DW'(1);
    else if (delay > DW'(MAX_DELAY))
      eff = DW'(MAX_DELAY);
    else
      eff = delay;
  end

  always_comb begin
    res = '0;
    case (op)
      2'b00:   res    = in_a;
      2'b01:   res[0] = (|in_a) && (|in_b);
      2'b10:   res    = in_a & in_b;
      default: res    = in_a ^ in_b;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = (eff == cur_delay);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready && !flush;

  // Samples in one burst share a latency and arrive one per cycle, so the
  // insertion slot is always vacated by the shift in the same edge.
  always_comb begin
    sv_n = {1'b0, sv[MAX_DELAY:2]};
    sd_n = {WIDTH'(0), sd[MAX_DELAY:2]};
    if (accept) begin
      for (int unsigned i = 1; i <= MAX_DELAY; i++) begin
        if (32'(eff) == i) begin
          sv_n[i] = 1'b1;
          sd_n[i] = res;
        end
      end
    end
  end

  // In-flight count: +1 on accept, -1 when a sample moves onto the output.
  always_comb begin
    if (flush)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + DW'(accept) - DW'(sv[1]);
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept)
            state_nxt = RUN;
        end
        RUN: begin
          if (in_valid && (eff != cur_delay))
            state_nxt = DRAIN;
          else if (!accept && (cnt_nxt == '0))
            state_nxt = IDLE;
        end
        DRAIN: begin
          if (cnt_nxt == '0)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_delay <= DW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((state == IDLE) && accept)
        cur_delay <= eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv        <= '0;
      out_valid <= 1'b0;
`ifdef NBA_DELAY_LINE_XINIT_EN
      out_data  <= 'x;
`else
      out_data  <= '0;
`endif
    end else if (flush) begin
      sv        <= '0;
      out_valid <= 1'b0;
    end else begin
      sv        <= sv_n;
      out_valid <= sv[1];
      if (sv[1])
        out_data <= sd[1];
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    sd <= sd_n;
  end

  assign busy = (cnt != '0);

endmodule
